// File: rtl/axis_pixel_writer.sv
// rtl/axis_pixel_writer.sv - byte stream to framebuffer pixel writer with format unpack, 2x2 decimation and frame-length recovery
// Optional statistics counters are built when PIXEL_WRITER_STATS_EN is defined.
module axis_pixel_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int CH_W       = 5,
   parameter int START_SYNC = 1
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic [7:0]        TDATA,
   input  logic              TVALID,
   input  logic              TLAST,
   output logic              TREADY,
   input  logic [1:0]        mode,
   input  logic              decim,
   output logic [CH_W-1:0]   red,
   output logic [CH_W-1:0]   green,
   output logic [CH_W-1:0]   blue,
   output logic [ADDR_W-1:0] index,
   output logic              valid,
   input  logic              wr_ready,
   output logic              err_short,
   output logic              err_long,
   output logic [15:0]       frame_cnt,
   output logic [7:0]        err_cnt
);

   localparam int COL_W = (H_RES > 2) ? $clog2(H_RES) : 1;
   localparam int ROW_W = (V_RES > 2) ? $clog2(V_RES) : 1;

   localparam logic [1:0] S_SYNC  = 2'd0;
   localparam logic [1:0] S_BYTE0 = 2'd1;
   localparam logic [1:0] S_BYTE1 = 2'd2;
   localparam logic [1:0] S_RESET = (START_SYNC != 0) ? S_SYNC : S_BYTE0;

   logic [1:0]        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic              decim_q, decim_d;
   logic              frame_start_q, frame_start_d;
   logic [7:0]        byte0_q, byte0_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] widx_q, widx_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [CH_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic              valid_q, valid_d;
   logic              err_short_q, err_short_d;
   logic              err_long_q, err_long_d;

   logic              accept, pix_done, clear_cnt, last_col, last_pix, write_ok;
   logic [1:0]        mode_eff;
   logic              decim_eff;
   logic [7:0]        b0, r8, g8, b8;

   assign TREADY   = ~RESET & (~valid_q | wr_ready);
   assign accept   = TVALID & TREADY;
   assign last_col = (col_q == COL_W'(H_RES - 1));
   assign last_pix = last_col && (row_q == ROW_W'(V_RES - 1));

   assign red       = red_q;
   assign green     = green_q;
   assign blue      = blue_q;
   assign index     = index_q;
   assign valid     = valid_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;

   // Unpack the current pixel into 8-bit channels; format comes live from the inputs until the first byte of a frame latches it
   always_comb begin
      mode_eff  = frame_start_q ? mode  : mode_q;
      decim_eff = frame_start_q ? decim : decim_q;
      b0        = (state_q == S_BYTE1) ? byte0_q : TDATA;
      case (mode_eff)
         2'd0: begin
            r8 = {b0[7:3], b0[7:5]};
            g8 = {b0[2:0], TDATA[7:5], b0[2:1]};
            b8 = {TDATA[4:0], TDATA[4:2]};
         end
         2'd1: begin
            r8 = {b0[6:2], b0[6:4]};
            g8 = {b0[1:0], TDATA[7:5], b0[1:0], TDATA[7]};
            b8 = {TDATA[4:0], TDATA[4:2]};
         end
         default: begin
            r8 = TDATA;
            g8 = TDATA;
            b8 = TDATA;
         end
      endcase
   end

   assign write_ok = ~decim_eff | (~col_q[0] & ~row_q[0]);

`ifdef PIXEL_WRITER_STATS_EN
   logic        good_frame;
   logic [15:0] frame_cnt_q;
   logic [7:0]  err_cnt_q;
`endif

   // Byte sequencing, pixel completion, write strobe and frame-boundary recovery
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      decim_d       = decim_q;
      frame_start_d = frame_start_q;
      byte0_d       = byte0_q;
      col_d         = col_q;
      row_d         = row_q;
      widx_d        = widx_q;
      index_d       = index_q;
      red_d         = red_q;
      green_d       = green_q;
      blue_d        = blue_q;
      valid_d       = valid_q & ~wr_ready;
      err_short_d   = 1'b0;
      err_long_d    = 1'b0;
      pix_done      = 1'b0;
      clear_cnt     = 1'b0;
`ifdef PIXEL_WRITER_STATS_EN
      good_frame    = 1'b0;
`endif

      if (accept) begin
         case (state_q)
            S_SYNC: begin
               if (TLAST) begin
                  state_d       = S_BYTE0;
                  frame_start_d = 1'b1;
               end
            end
            S_BYTE0: begin
               if (frame_start_q) begin
                  mode_d        = mode;
                  decim_d       = decim;
                  frame_start_d = 1'b0;
               end
               if (mode_eff[1]) begin
                  pix_done = 1'b1;
               end else if (TLAST) begin
                  // Frame ended halfway through a pixel: drop the half pixel
                  err_short_d   = 1'b1;
                  clear_cnt     = 1'b1;
                  frame_start_d = 1'b1;
               end else begin
                  byte0_d = TDATA;
                  state_d = S_BYTE1;
               end
            end
            S_BYTE1: begin
               pix_done = 1'b1;
            end
            default: begin
               state_d = S_RESET;
            end
         endcase
      end

      if (pix_done) begin
         state_d = S_BYTE0;
         if (write_ok) begin
            valid_d = 1'b1;
            red_d   = CH_W'(r8 >> (8 - CH_W));
            green_d = CH_W'(g8 >> (8 - CH_W));
            blue_d  = CH_W'(b8 >> (8 - CH_W));
            index_d = widx_q;
            widx_d  = widx_q + ADDR_W'(1);
         end
         if (last_pix) begin
            clear_cnt = 1'b1;
            if (TLAST) begin
               frame_start_d = 1'b1;
`ifdef PIXEL_WRITER_STATS_EN
               good_frame    = 1'b1;
`endif
            end else begin
               // Frame overran: resynchronise on the next TLAST
               err_long_d = 1'b1;
               state_d    = S_SYNC;
            end
         end else if (TLAST) begin
            err_short_d   = 1'b1;
            clear_cnt     = 1'b1;
            frame_start_d = 1'b1;
         end else if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end

      if (clear_cnt) begin
         col_d  = '0;
         row_d  = '0;
         widx_d = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q       <= S_RESET;
         mode_q        <= 2'd0;
         decim_q       <= 1'b0;
         frame_start_q <= 1'b1;
         byte0_q       <= 8'd0;
         col_q         <= '0;
         row_q         <= '0;
         widx_q        <= '0;
         index_q       <= '0;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
         valid_q       <= 1'b0;
         err_short_q   <= 1'b0;
         err_long_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         decim_q       <= decim_d;
         frame_start_q <= frame_start_d;
         byte0_q       <= byte0_d;
         col_q         <= col_d;
         row_q         <= row_d;
         widx_q        <= widx_d;
         index_q       <= index_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
         valid_q       <= valid_d;
         err_short_q   <= err_short_d;
         err_long_q    <= err_long_d;
      end
   end

`ifdef PIXEL_WRITER_STATS_EN
   // Good-frame counter (wrapping) and saturating error counter
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         frame_cnt_q <= 16'd0;
         err_cnt_q   <= 8'd0;
      end else begin
         if (good_frame) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if ((err_short_d | err_long_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`else
   assign frame_cnt = 16'd0;
   assign err_cnt   = 8'd0;
`endif

endmodule

// File: doc/axis_pixel_writer.md
# axis_pixel_writer

Parametrised AXI-Stream-to-framebuffer writer in the video_stream capture path. It sits after the image filter and before the frame BRAM. It assembles camera bytes into pixels in one of three input formats, optionally decimates 2x2, and emits per-channel colour, a linear write index and a write strobe. Frame alignment is tracked from TLAST, and short and long frames are detected and recovered.

## Interface
- H_RES, 640, active pixels per line (even, ≥2)
- V_RES, 480, lines per frame (even, ≥2)
- ADDR_W, 19, width of index (must hold H_RES*V_RES-1)
- CH_W, 5, output bits per colour channel (1..8)
- START_SYNC, 1, 1 = discard input after reset until first TLAST; 0 = first byte after reset is pixel 0
- clk  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- TDATA  in  8  stream byte
- TVALID  in  1  byte valid
- TLAST  in  1  last byte of frame
- TREADY  out  1  byte accepted when TVALID&TREADY
- mode  in  2  0 RGB565, 1 RGB555, 2 GRAY8, 3 reserved (treated as GRAY8)
- decim  in  1  2x2 decimation enable
- red, green, blue  out  CH_W each  pixel channels
- index  out  ADDR_W  linear write address
- valid  out  1  write strobe; holds until wr_ready
- wr_ready  in  1  memory accepts write when valid&wr_ready
- err_short, err_long  out  1 each  one-cycle error pulses
- frame_cnt  out  16  completed frames (stats)
- err_cnt  out  8  saturating error count (stats)

## Operation
- Reset (async, RESET=1): all outputs 0; counters cleared; state SYNC if START_SYNC else BYTE0.
- States: SYNC (accept and discard; go to BYTE0 on an accepted TLAST), BYTE0, BYTE1 (2-byte modes only).
- mode and decim are latched only at frame start: on leaving reset, on leaving SYNC, or after an accepted TLAST. Changes mid-frame are ignored.
- RGB565, high byte first: byte0={R[4:0],G[5:3]}, byte1={G[2:0],B[4:0]}.
- RGB555: byte0={x,R[4:0],G[4:3]}, byte1={G[2:0],B[4:0]}.
- GRAY8: each byte is one pixel; R=G=B=byte.
- Channel scaling: n-bit source widened to 8 bits by MSB replication ({s,s[4:2]} for n=5, {s,s[5:4]} for n=6), then the top CH_W bits are taken.
- col (0..H_RES-1) and row (0..V_RES-1) advance per completed pixel. col wraps to 0 and increments row.
- decim=1: only pixels with col[0]=0 and row[0]=0 are written. The rest complete silently.
- index starts at 0 each frame and increments after each written pixel. Its maximum is H_RES*V_RES-1, or H_RES*V_RES/4-1 when decimating.
- Short frame: TLAST on any byte that is not the final byte of pixel (H_RES-1, V_RES-1).
  - err_short pulses.
  - If TLAST completes a pixel, that pixel is written normally.
  - A partial pixel (TLAST on byte0 of a 2-byte mode) is discarded.
  - Counters and index return to 0; state returns to BYTE0.
- Long frame: last pixel completes without TLAST.
  - The pixel is written.
  - err_long pulses.
  - State goes to SYNC until TLAST.
- A correct frame end (TLAST on the final byte of the last pixel) increments frame_cnt (wraps). Counters reset.

## Timing
- TREADY = !valid | wr_ready. This is combinational from registered valid and the wr_ready input. TREADY is 0 during reset.
- Latency: the accepted final byte of a pixel at edge N gives valid, data and index registered at edge N+1.
- valid, red, green, blue and index hold stable while valid & !wr_ready. No byte is accepted in that time.
- Throughput: one write per byte in GRAY8; one write per two bytes otherwise.
- err_short and err_long assert on the edge after the offending byte, for exactly one cycle.
- A reset asserted mid-frame aborts immediately: valid=0, any pending write is lost, and state is SYNC or BYTE0 per START_SYNC.

## Configuration
- PIXEL_WRITER_STATS_EN defined:
  - frame_cnt counts good frames.
  - err_cnt increments on each err_short or err_long pulse, saturating at 255.
- Not defined: frame_cnt and err_cnt are tied to 0 and no counter logic is built. Error pulses are unaffected.

## Test plan
- H_RES=4, V_RES=2, CH_W=5, START_SYNC=0, mode 0, wr_ready=1. Send 16 bytes alternating F8,00 with TLAST on byte 16.
  - Expect 8 writes, index 0..7, each R=1F, G=00, B=00.
  - frame_cnt=1; no error pulses.
- Same configuration, GRAY8, decim=1, bytes 00..07 with TLAST on 07.
  - Expect 2 writes: index 0 with data 00→R=G=B=00, index 1 with data 02→R=G=B=00.
  - Then bytes 80..87: index 0 and 1 with R=10.
- Short frame: RGB565 with TLAST on byte 5 (byte0 of pixel 2).
  - Expect 2 writes, err_short pulse, partial pixel dropped.
  - The next byte pair is written at index 0.
- Long frame: RGB565, 18 bytes with no TLAST, then 2 bytes with TLAST.
  - Expect 8 writes and an err_long pulse after byte 16.
  - Bytes 17..20 are discarded (SYNC).
  - Next frame writes from index 0; err_cnt=1 with PIXEL_WRITER_STATS_EN.
- Backpressure: hold wr_ready=0 for 5 cycles during a write.
  - TREADY=0 throughout; valid, data and index stable.
  - No byte lost; the write completes on the first wr_ready=1 cycle.
- START_SYNC=1: assert RESET mid-stream, release, then send 3 bytes with TLAST on the 3rd.
  - No writes, no errors.
  - The following frame writes normally from index 0.
